// File: rtl/datamem_pkg.sv
// Shared types and helpers for the lane-parallel data memory.
package datamem_pkg;

   typedef enum logic {ST_CLEAR, ST_IDLE} state_e;

   localparam int MAX_DW    = 1024;
   localparam int MAX_LANES = 128;

   // Lanes whose mask bit is set take new_w, the rest keep old_w.
   function automatic logic [MAX_DW-1:0] lane_merge(input logic [MAX_DW-1:0]    old_w,
                                                    input logic [MAX_DW-1:0]    new_w,
                                                    input logic [MAX_LANES-1:0] mask,
                                                    input int unsigned          lane_w);
      logic [MAX_DW-1:0] lane_ones;
      logic [MAX_DW-1:0] m;
      lane_ones = ({{(MAX_DW-1){1'b0}}, 1'b1} << lane_w) - {{(MAX_DW-1){1'b0}}, 1'b1};
      m = '0;
      for (int unsigned l = 0; l < MAX_LANES; l++) begin
         if (mask[l]) m = m | (lane_ones << (l * lane_w));
      end
      return (old_w & ~m) | (new_w & m);
   endfunction

endpackage

// File: rtl/datamem_lanes_if.sv
// Read/write/clear bus between the load/store unit and datamem_lanes.
interface datamem_lanes_if #(
   parameter int ADDR_W = 8,
   parameter int LANE_W = 8,
   parameter int LANES  = 8
);
   localparam int DW = LANES * LANE_W;

   logic              rden;
   logic [ADDR_W-1:0] rdaddress;
   logic [DW-1:0]     q;
   logic              q_valid;
   logic              wren;
   logic [ADDR_W-1:0] wraddress;
   logic [LANES-1:0]  byteena;
   logic [DW-1:0]     data;
   logic              init_req;
   logic              busy;

   modport master (
      output rden, rdaddress, wren, wraddress, byteena, data, init_req,
      input  q, q_valid, busy
   );

   modport slave (
      input  rden, rdaddress, wren, wraddress, byteena, data, init_req,
      output q, q_valid, busy
   );
endinterface

// File: rtl/datamem_lane.sv
// One byte lane: LANE_W x 2**ADDR_W simple dual-port RAM with registered read.
module datamem_lane #(
   parameter int ADDR_W = 8,
   parameter int LANE_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [LANE_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [LANE_W-1:0] rdata_o
);
   logic [LANE_W-1:0] mem [0:(1<<ADDR_W)-1];
   logic [LANE_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end

   // Read register returns pre-write data on a same-address collision.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)   rdata_q <= '0;
      else if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/datamem_lanes.sv
// Lane-parallel data memory with clear engine, write bypass and optional output stage.
module datamem_lanes
   import datamem_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int LANE_W  = 8,
   parameter int LANES   = 8,
   parameter bit OUT_REG = 1'b0,
   parameter bit BYPASS  = 1'b1
) (
   input  logic            clock,
   input  logic            reset_n,
   datamem_lanes_if.slave  bus
);
   localparam int DW     = LANES * LANE_W;
   localparam int STAGES = OUT_REG ? 2 : 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              idle, clr, re, we;

   assign idle = (state_q == ST_IDLE);
   assign clr  = ~idle;
   assign re   = bus.rden & idle;
   assign we   = bus.wren & idle;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (bus.init_req) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   assign bus.busy = clr;

   logic [LANES-1:0][LANE_W-1:0] ram_q;
   logic [ADDR_W-1:0]            waddr;

   assign waddr = clr ? cnt_q : bus.wraddress;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      datamem_lane #(.ADDR_W(ADDR_W), .LANE_W(LANE_W)) u_lane (
         .clk_i   (clock),
         .rst_ni  (reset_n),
         .we_i    (clr | (we & bus.byteena[i])),
         .waddr_i (waddr),
         .wdata_i (clr ? '0 : bus.data[i*LANE_W +: LANE_W]),
         .re_i    (re),
         .raddr_i (bus.rdaddress),
         .rdata_o (ram_q[i])
      );
   end

   // Bypass state is captured alongside the RAM read so q holds when idle.
   logic [LANES-1:0] byp_mask_q;
   logic [DW-1:0]    byp_data_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         byp_mask_q <= '0;
         byp_data_q <= '0;
      end else if (re) begin
         byp_mask_q <= (BYPASS && we && (bus.rdaddress == bus.wraddress)) ? bus.byteena : '0;
         byp_data_q <= bus.data;
      end
   end

   logic [DW-1:0] q1;
   assign q1 = DW'(lane_merge(MAX_DW'(ram_q), MAX_DW'(byp_data_q),
                              MAX_LANES'(byp_mask_q), LANE_W));

   logic [STAGES:0] vld_pipe;
   assign vld_pipe[0] = re;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) vld_pipe[STAGES:1] <= '0;
      else          vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
   end

   assign bus.q_valid = vld_pipe[STAGES];

   if (OUT_REG) begin : g_oreg
      logic [DW-1:0] q_q;
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) q_q <= '0;
         else          q_q <= q1;
      end
      assign bus.q = q_q;
   end else begin : g_noreg
      assign bus.q = q1;
   end
endmodule
